pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Central pipeline controller; drives the stall[5:0] vector and flush strobes consumed by pc_reg, if_id,
//  id_ex, ex_mem and mem_wb. Arbitrates per-stage stall requests, accepts taken-branch redirects from EX,
//  holds a redirect until fetch acknowledges it, and kills wrong-path instructions meanwhile.
//  Sits beside the pipeline registers; purely a control block, no datapath besides target PC and counter.
// PARAMETERS
//  PC_W    32  width of redirect target (matches RegBus)
//  PERF_W  32  width of saturating stall-cycle counter
// PORTS
//  clk              in   1      clock, all state on posedge
//  rst              in   1      asynchronous, active-high reset (RstEnable)
//  stallreq_if      in   1      fetch busy (icache/mem port not ready)
//  stallreq_id      in   1      load-use hazard in ID
//  stallreq_ex      in   1      multi-cycle op in EX
//  stallreq_mem     in   1      data memory access busy
//  branch_flag_i    in   1      EX resolved taken branch/jump this cycle
//  branch_target_i  in   PC_W   target of that branch
//  redirect_ack_i   in   1      pc_reg consumed redirect this cycle
//  stall            out  6      [0]pc [1]IF [2]ID [3]EX [4]MEM [5]WB; 1=Stop
//  if_idflush_o     out  1      kill IF/ID contents at next posedge
//  id_exflush_o     out  1      kill ID/EX contents at next posedge (feeds id_exflush_i)
//  redirect_valid_o out  1      redirect pending toward pc_reg
//  redirect_pc_o    out  PC_W   pending redirect target
//  stall_cycles_o   out  PERF_W cycles with any stall bit set, saturating
// BEHAVIOUR
//  Reset (async, any time incl. mid-redirect): state=IDLE, redirect_valid_o=0, redirect_pc_o=ZeroWord,
//   stall_cycles_o=0; combinational outputs then evaluate to stall=6'b000000, both flushes 0.
//  Stall priority (combinational, highest wins): mem->6'b011111, ex->6'b001111, id->6'b000111,
//   if->6'b000011, none->6'b000000. Stall of stage k with k+1 free makes the register after k emit bubble.
//  ex_busy = stall[3]. Branch accepted iff branch_flag_i && !ex_busy; unaccepted branch ignored (EX holds
//   and re-presents it).
//  FSM, 2 states:
//   IDLE: on accepted branch -> if_idflush_o=1 and id_exflush_o=1 same cycle (combinational);
//     next posedge: redirect_pc_o<=branch_target_i, redirect_valid_o<=1, state->REDIR_WAIT.
//   REDIR_WAIT: redirect_valid_o=1, redirect_pc_o stable; if_idflush_o=1 every cycle (wrong-path kill);
//     id_exflush_o=0. On redirect_ack_i: next posedge valid<=0, state->IDLE, flush drops that edge.
//     Accepted branch while in REDIR_WAIT is illegal (upstream already flushed); if it occurs, newer target
//     overwrites, flushes reasserted, state stays REDIR_WAIT; bench asserts it never happens.
//  redirect_ack_i while redirect_valid_o=0: ignored.
//  stallreq_if during REDIR_WAIT: stall bits asserted as usual; redirect held until ack, no timeout.
//  Flush vs stall same cycle: flush wins at the register (id_ex already gives flush priority); controller
//   still drives stall normally.
//  Counter: +1 each posedge where stall!=0; holds at all-ones (no wrap). Width PERF_W, unsigned.
//  Latency: stall/flush zero-cycle (comb from requests); redirect visible 1 cycle after accepted branch.
// STRUCTURE
//  defines.v gains: `StallBus 5:0, `STALL_NONE/IF/ID/EX/MEM encodings, FSM state codes
//   `CTRL_IDLE/`CTRL_REDIR; reuse `Stop/`NoStop/`RstEnable/`ZeroWord.
//  One sub-module natural: sat_counter (PERF_W, inc, count); rest is flat always blocks.
// TESTING
//  rst=1 mid REDIR_WAIT -> immediately valid=0, stall=0, counter=0; after release state IDLE.
//  stallreq_id=1 alone -> stall=6'b000111; with stallreq_mem=1 too -> 6'b011111.
//  branch_flag_i=1,target=32'h0000_0100, no stalls -> both flushes 1 that cycle; next cycle
//   redirect_valid_o=1, redirect_pc_o=32'h100, if_idflush_o=1; ack after 3 cycles -> valid=0 next edge.
//  branch_flag_i=1 with stallreq_ex=1 -> no flush, no redirect; drop stallreq_ex next cycle -> accepted then.
//  stallreq_if=1 for 5 cycles -> stall=6'b000011 each, stall_cycles_o=5; preload 2^PERF_W-1 -> stays max.
//  redirect_ack_i pulse in IDLE -> no state change, outputs unchanged.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared stall encodings, controller state type and stall-priority helper
// for the pipeline controller.
package pipe_ctrl_pkg;

    localparam int STALL_BUS_W = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [STALL_BUS_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_BUS_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_BUS_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_BUS_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_BUS_W-1:0] STALL_MEM  = 6'b011111;

    localparam int STALL_EX_BIT = 3;

    typedef enum logic {
        CTRL_IDLE  = 1'b0,
        CTRL_REDIR = 1'b1
    } ctrl_state_t;

    // The deepest requesting stage wins; every stage upstream of it is frozen too.
    function automatic logic [STALL_BUS_W-1:0] stall_encode(
        input logic req_if,
        input logic req_id,
        input logic req_ex,
        input logic req_mem
    );
        logic [STALL_BUS_W-1:0] enc;
        enc = STALL_NONE;
        if (req_mem)     enc = STALL_MEM;
        else if (req_ex) enc = STALL_EX;
        else if (req_id) enc = STALL_ID;
        else if (req_if) enc = STALL_IF;
        return enc;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Unsigned up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall arbitration, taken-branch redirect handshake
// toward pc_reg, wrong-path flush strobes and a stall-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_if,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic              branch_flag_i,
    input  logic [PC_W-1:0]   branch_target_i,
    input  logic              redirect_ack_i,
    output logic [5:0]        stall,
    output logic              if_idflush_o,
    output logic              id_exflush_o,
    output logic              redirect_valid_o,
    output logic [PC_W-1:0]   redirect_pc_o,
    output logic [PERF_W-1:0] stall_cycles_o
);

    ctrl_state_t ctrl_state;
    logic        ex_busy;
    logic        branch_accept;

    assign stall         = stall_encode(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
    assign ex_busy       = (stall[STALL_EX_BIT] == STOP);
    assign branch_accept = branch_flag_i && !ex_busy;

    // IF/ID keeps being killed for as long as fetch has not taken the redirect.
    assign if_idflush_o = branch_accept || (ctrl_state == CTRL_REDIR);
    assign id_exflush_o = branch_accept;

    // A newer accepted branch overrides a stale ack so the latest target always wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_state       <= CTRL_IDLE;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
        end else begin
            case (ctrl_state)
                CTRL_IDLE: begin
                    if (branch_accept) begin
                        redirect_pc_o    <= branch_target_i;
                        redirect_valid_o <= 1'b1;
                        ctrl_state       <= CTRL_REDIR;
                    end
                end
                CTRL_REDIR: begin
                    if (branch_accept) begin
                        redirect_pc_o    <= branch_target_i;
                        redirect_valid_o <= 1'b1;
                    end else if (redirect_ack_i) begin
                        redirect_valid_o <= 1'b0;
                        ctrl_state       <= CTRL_IDLE;
                    end
                end
                default: begin
                    redirect_valid_o <= 1'b0;
                    ctrl_state       <= CTRL_IDLE;
                end
            endcase
        end
    end

    sat_counter #(
        .W(PERF_W)
    ) u_stall_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall != STALL_NONE),
        .count (stall_cycles_o)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus pushes expected outputs from a
// behavioural model, an independent monitor pops and compares every cycle.
module tb_pipe_ctrl;

    localparam int PC_W   = 32;
    localparam int PERF_W = 6;
    localparam int CNT_MAX = (1 << PERF_W) - 1;

    logic              clk;
    logic              rst;
    logic              stallreq_if;
    logic              stallreq_id;
    logic              stallreq_ex;
    logic              stallreq_mem;
    logic              branch_flag_i;
    logic [PC_W-1:0]   branch_target_i;
    logic              redirect_ack_i;
    logic [5:0]        stall;
    logic              if_idflush_o;
    logic              id_exflush_o;
    logic              redirect_valid_o;
    logic [PC_W-1:0]   redirect_pc_o;
    logic [PERF_W-1:0] stall_cycles_o;

    pipe_ctrl #(
        .PC_W  (PC_W),
        .PERF_W(PERF_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stallreq_if     (stallreq_if),
        .stallreq_id     (stallreq_id),
        .stallreq_ex     (stallreq_ex),
        .stallreq_mem    (stallreq_mem),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .redirect_ack_i  (redirect_ack_i),
        .stall           (stall),
        .if_idflush_o    (if_idflush_o),
        .id_exflush_o    (id_exflush_o),
        .redirect_valid_o(redirect_valid_o),
        .redirect_pc_o   (redirect_pc_o),
        .stall_cycles_o  (stall_cycles_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]      stall;
        logic            ifFlush;
        logic            exFlush;
        logic            valid;
        logic [PC_W-1:0] pc;
        int              count;
    } expect_t;

    expect_t expQ[$];

    int vectors  = 0;
    int miscomps = 0;

    // Behavioural model: a pending redirect, its target, and a stall-cycle tally.
    bit              mPending;
    logic [PC_W-1:0] mPc;
    int              mCount;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscomps++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPending = 0;
        mPc      = '0;
        mCount   = 0;
    endtask

    // Drive one cycle of inputs, predict the outputs, then advance the model at the edge.
    task automatic applyStimulus(input bit rIf, input bit rId, input bit rEx, input bit rMem,
                                 input bit br, input logic [PC_W-1:0] tgt, input bit ack);
        expect_t e;
        int      depth;
        bit      accept;
        @(negedge clk);
        stallreq_if     = rIf;
        stallreq_id     = rId;
        stallreq_ex     = rEx;
        stallreq_mem    = rMem;
        branch_flag_i   = br;
        branch_target_i = tgt;
        redirect_ack_i  = ack;
        depth = rMem ? 5 : rEx ? 4 : rId ? 3 : rIf ? 2 : 0;
        e.stall   = 6'((1 << depth) - 1);
        accept    = br && !(rMem || rEx);
        e.ifFlush = accept || mPending;
        e.exFlush = accept;
        e.valid   = mPending;
        e.pc      = mPc;
        e.count   = mCount;
        #1;
        expQ.push_back(e);
        @(posedge clk);
        if (depth != 0 && mCount < CNT_MAX) mCount++;
        if (accept) begin
            mPending = 1;
            mPc      = tgt;
        end else if (mPending && ack) begin
            mPending = 0;
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, '0, 0);
    endtask

    // Monitor: compares whatever the DUT presents against the oldest prediction.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("stall",    longint'(stall),            longint'(e.stall));
                checkOutput("ifFlush",  longint'(if_idflush_o),     longint'(e.ifFlush));
                checkOutput("exFlush",  longint'(id_exflush_o),     longint'(e.exFlush));
                checkOutput("rdValid",  longint'(redirect_valid_o), longint'(e.valid));
                checkOutput("rdPc",     longint'(redirect_pc_o),    longint'(e.pc));
                checkOutput("stallCnt", longint'(stall_cycles_o),   longint'(e.count));
                if (redirect_valid_o && id_exflush_o) begin
                    miscomps++;
                    $display("[TB] FAIL illegalBranch: branch accepted while redirect pending at %0t", $time);
                end
            end
        end
    end

    initial begin
        bit rIf, rId, rEx, rMem, br, ack;
        stallreq_if     = 0;
        stallreq_id     = 0;
        stallreq_ex     = 0;
        stallreq_mem    = 0;
        branch_flag_i   = 0;
        branch_target_i = '0;
        redirect_ack_i  = 0;
        rst             = 1;
        modelReset();
        #3;
        checkOutput("rstValid", longint'(redirect_valid_o), 0);
        checkOutput("rstPc",    longint'(redirect_pc_o),    0);
        checkOutput("rstCnt",   longint'(stall_cycles_o),   0);
        checkOutput("rstStall", longint'(stall),            0);
        checkOutput("rstFlush", longint'({if_idflush_o, id_exflush_o}), 0);
        @(negedge clk);
        rst = 0;

        // Stall priority.
        applyStimulus(0, 1, 0, 0, 0, '0, 0);
        applyStimulus(0, 1, 0, 1, 0, '0, 0);
        applyStimulus(1, 0, 1, 0, 0, '0, 0);
        applyStimulus(1, 0, 0, 0, 0, '0, 0);

        // Taken branch, ack after three pending cycles.
        applyStimulus(0, 0, 0, 0, 1, 32'h0000_0100, 0);
        applyStimulus(0, 0, 0, 0, 0, '0, 0);
        applyStimulus(1, 0, 0, 0, 0, '0, 0);
        applyStimulus(0, 0, 0, 0, 0, '0, 1);
        idleCycles(2);

        // Branch blocked by EX, accepted once EX frees up.
        applyStimulus(0, 0, 1, 0, 1, 32'h0000_0200, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h0000_0200, 0);
        applyStimulus(0, 0, 0, 1, 0, '0, 1);
        applyStimulus(0, 0, 0, 0, 0, '0, 1);

        // Stray ack while idle.
        applyStimulus(0, 0, 0, 0, 0, '0, 1);
        idleCycles(1);

        // Reset mid-redirect.
        applyStimulus(0, 0, 0, 0, 1, 32'hDEAD_BEE0, 0);
        applyStimulus(0, 0, 0, 0, 0, '0, 0);
        #2;
        rst = 1;
        #1;
        modelReset();
        checkOutput("midRstValid", longint'(redirect_valid_o), 0);
        checkOutput("midRstStall", longint'(stall),            0);
        checkOutput("midRstCnt",   longint'(stall_cycles_o),   0);
        checkOutput("midRstFlush", longint'(if_idflush_o),     0);
        @(negedge clk);
        rst = 0;
        idleCycles(1);

        // Five fetch-stall cycles from a cleared counter.
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0, '0, 0);
        #1;
        checkOutput("cntFive", longint'(stall_cycles_o), 5);

        // Randomized traffic; branches only offered when no redirect is pending.
        for (int i = 0; i < 300; i++) begin
            rIf  = ($urandom_range(4) == 0);
            rId  = ($urandom_range(5) == 0);
            rEx  = ($urandom_range(5) == 0);
            rMem = ($urandom_range(6) == 0);
            br   = !mPending && ($urandom_range(3) == 0);
            ack  = mPending ? ($urandom_range(2) == 0) : ($urandom_range(5) == 0);
            applyStimulus(rIf, rId, rEx, rMem, br, PC_W'($urandom), ack);
        end

        // Drive the counter into saturation and keep stalling.
        for (int i = 0; i < CNT_MAX + 8; i++) applyStimulus(1, 0, 0, 0, 0, '0, 0);
        #1;
        checkOutput("cntSat", longint'(stall_cycles_o), CNT_MAX);
        idleCycles(2);

        @(negedge clk);
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomps);
        $finish;
    end

endmodule
